// File: rtl/rsc_encoder.sv
// Rate-1/2 recursive systematic convolutional encoder, g0 = 1+D^2+D^3 (feedback), g1 = 1+D+D^3.
// Define RSC_ENC_TERMINATION_EN to append three trellis-termination pairs to every block.
module rsc_encoder #(
  parameter int unsigned KW = 13
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Start,
  input  logic [KW-1:0] BlockLen,
  input  logic          InBit,
  input  logic          InValid,
  output logic          InReady,
  output logic          OutSys,
  output logic          OutPar,
  output logic          OutTail,
  output logic          OutValid,
  input  logic          OutReady,
  output logic          Busy,
  output logic          Done
);

`ifdef RSC_ENC_TERMINATION_EN
  typedef enum logic [1:0] {StIdle, StData, StTail} state_e;
`else
  typedef enum logic [1:0] {StIdle, StData} state_e;
`endif

  state_e        r_state, w_state_nxt;
  logic [2:0]    r_s, w_s_nxt;  // [0] = s1 (newest), [2] = s3 (oldest)
  logic [KW-1:0] r_cnt, w_cnt_nxt;
  logic [KW-1:0] r_len, w_len_nxt;
  logic          r_sys, w_sys_nxt;
  logic          r_par, w_par_nxt;
  logic          r_tail, w_tail_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_last, w_last_nxt;
`ifdef RSC_ENC_TERMINATION_EN
  logic [1:0]    r_tcnt, w_tcnt_nxt;
`endif

  logic w_adv;
  logic w_a;

  // The output register can take a new pair when empty or being drained this cycle.
  assign w_adv = !r_valid || OutReady;
  assign w_a   = InBit ^ r_s[1] ^ r_s[2];

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_sys_nxt   = r_sys;
    w_par_nxt   = r_par;
    w_tail_nxt  = r_tail;
    w_last_nxt  = r_last;
    w_valid_nxt = r_valid && !OutReady;
`ifdef RSC_ENC_TERMINATION_EN
    w_tcnt_nxt  = r_tcnt;
`endif
    case (r_state)
      StIdle: begin
        if (Start && (BlockLen != '0)) begin
          w_state_nxt = StData;
          w_s_nxt     = 3'b000;
          w_cnt_nxt   = '0;
          w_len_nxt   = BlockLen;
        end
      end
      StData: begin
        if (InValid && w_adv) begin
          w_sys_nxt   = InBit;
          w_par_nxt   = w_a ^ r_s[0] ^ r_s[2];
          w_tail_nxt  = 1'b0;
          w_valid_nxt = 1'b1;
          w_last_nxt  = 1'b0;
          w_s_nxt     = {r_s[1], r_s[0], w_a};
          w_cnt_nxt   = r_cnt + KW'(1);
          if (r_cnt == r_len - KW'(1)) begin
`ifdef RSC_ENC_TERMINATION_EN
            w_state_nxt = StTail;
            w_tcnt_nxt  = 2'd0;
`else
            w_state_nxt = StIdle;
            w_last_nxt  = 1'b1;
`endif
          end
        end
      end
`ifdef RSC_ENC_TERMINATION_EN
      StTail: begin
        // Feeding u = s2^s3 forces the feedback bit to zero, flushing the register.
        if (w_adv) begin
          w_sys_nxt   = r_s[1] ^ r_s[2];
          w_par_nxt   = r_s[0] ^ r_s[2];
          w_tail_nxt  = 1'b1;
          w_valid_nxt = 1'b1;
          w_last_nxt  = 1'b0;
          w_s_nxt     = {r_s[1], r_s[0], 1'b0};
          w_tcnt_nxt  = r_tcnt + 2'd1;
          if (r_tcnt == 2'd2) begin
            w_state_nxt = StIdle;
            w_last_nxt  = 1'b1;
          end
        end
      end
`endif
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= StIdle;
      r_s     <= 3'b000;
      r_cnt   <= '0;
      r_len   <= '0;
      r_sys   <= 1'b0;
      r_par   <= 1'b0;
      r_tail  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
`ifdef RSC_ENC_TERMINATION_EN
      r_tcnt  <= 2'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      r_sys   <= w_sys_nxt;
      r_par   <= w_par_nxt;
      r_tail  <= w_tail_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
`ifdef RSC_ENC_TERMINATION_EN
      r_tcnt  <= w_tcnt_nxt;
`endif
    end
  end

  assign InReady  = (r_state == StData) && w_adv;
  assign Busy     = (r_state != StIdle);
  assign Done     = r_valid && OutReady && r_last;
  assign OutSys   = r_sys;
  assign OutPar   = r_par;
  assign OutTail  = r_tail;
  assign OutValid = r_valid;

endmodule

// File: tb/tb_rsc_encoder.sv
// Randomized bench for rsc_encoder: a block-level reference model predicts every output pair,
// and a compare process checks each handshake, stall hold and Done pulse.
`timescale 1ns/1ps
module tb_rsc_encoder;
  localparam int KW = 13;
`ifdef RSC_ENC_TERMINATION_EN
  localparam int NT = 3;
  localparam logic [31:0] E_SYS = 32'b1000101;
  localparam logic [31:0] E_PAR = 32'b1111111;
  localparam logic [31:0] E_TAIL = 32'b0000111;
`else
  localparam int NT = 0;
  localparam logic [31:0] E_SYS = 32'b1000;
  localparam logic [31:0] E_PAR = 32'b1111;
  localparam logic [31:0] E_TAIL = 32'b0000;
`endif

  logic Clock = 1'b0;
  logic Reset, Start, InBit, InValid, OutReady;
  logic [KW-1:0] BlockLen;
  logic InReady, OutSys, OutPar, OutTail, OutValid, Busy, Done;

  typedef struct packed {logic sys; logic par; logic tail; logic last;} pair_t;
  pair_t exp_q[$];
  logic log_sys[$];
  logic log_par[$];
  logic log_tail[$];
  logic log_done[$];
  logic in_bits [0:63];

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  int rdy_pct = 100;
  int stall = 0;

  rsc_encoder #(.KW(KW)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .BlockLen(BlockLen),
    .InBit(InBit), .InValid(InValid), .InReady(InReady),
    .OutSys(OutSys), .OutPar(OutPar), .OutTail(OutTail), .OutValid(OutValid),
    .OutReady(OutReady), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  // Reference: run the code recursion over the whole block, then the flush pairs.
  task automatic model_block(input int k);
    logic s1, s2, s3, u, a;
    pair_t p;
    s1 = 0; s2 = 0; s3 = 0;
    for (int i = 0; i < k + NT; i++) begin
      u = (i < k) ? in_bits[i] : (s2 ^ s3);
      a = u ^ s2 ^ s3;
      p.sys = u;
      p.par = a ^ s1 ^ s3;
      p.tail = (i >= k);
      p.last = (i == k + NT - 1);
      exp_q.push_back(p);
      s3 = s2; s2 = s1; s1 = a;
    end
  endtask

  always @(posedge Clock) begin
    #1;
    if (stall > 0) begin
      OutReady = 1'b0;
      stall--;
    end else begin
      OutReady = ($urandom_range(99) < rdy_pct);
    end
  end

  logic pv = 1'b0, pr = 1'b0;
  logic [2:0] po = 3'b000;
  always @(negedge Clock) begin
    pair_t p;
    if (chk_en) begin
      if (pv && !pr) begin
        check("hold_valid", {31'd0, OutValid}, 32'd1);
        check("hold_data", {29'd0, OutSys, OutPar, OutTail}, {29'd0, po});
      end
      if (OutValid && !OutReady) check("inready_stall", {31'd0, InReady}, 32'd0);
      if (!Busy) check("inready_idle", {31'd0, InReady}, 32'd0);
      if (OutValid && OutReady) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_pair: got sys=%0b par=%0b with no pair expected", OutSys, OutPar);
        end else begin
          p = exp_q.pop_front();
          check("pair{sys,par,tail,done}", {28'd0, OutSys, OutPar, OutTail, Done}, {28'd0, p});
        end
        log_sys.push_back(OutSys);
        log_par.push_back(OutPar);
        log_tail.push_back(OutTail);
        log_done.push_back(Done);
      end else begin
        check("done_no_xfer", {31'd0, Done}, 32'd0);
      end
      pv = OutValid; pr = OutReady; po = {OutSys, OutPar, OutTail};
    end else begin
      pv = 1'b0;
    end
  end

  task automatic clear_log();
    log_sys.delete(); log_par.delete(); log_tail.delete(); log_done.delete();
  endtask

  task automatic pack_log(output logic [31:0] s, output logic [31:0] p, output logic [31:0] t,
                          output int didx);
    s = 0; p = 0; t = 0; didx = -1;
    for (int i = 0; i < log_sys.size(); i++) begin
      s = (s << 1) | 32'(log_sys[i]);
      p = (p << 1) | 32'(log_par[i]);
      t = (t << 1) | 32'(log_tail[i]);
      if (log_done[i]) didx = (didx == -1) ? i : -2;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 300) begin @(posedge Clock); #1; n++; end
    if (Busy) begin
      checks++; failures++;
      $display("FAIL wait_idle: Busy=%0b expected 0 within 300 cycles", Busy);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(posedge Clock); #1; n++; end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain: %0d pairs outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge Clock);
    #1;
  endtask

  task automatic feed(input int n, input int start_at, input int drop_at, input int stall_at,
                      input bit gaps);
    int t;
    for (int i = 0; i < n; i++) begin
      while (gaps && $urandom_range(3) == 0) begin InValid = 0; @(posedge Clock); #1; end
      InValid = 1; InBit = in_bits[i];
      t = 0;
      @(negedge Clock);
      while (!InReady && t < 300) begin @(negedge Clock); t++; end
      if (!InReady) begin
        checks++; failures++;
        $display("FAIL feed_timeout: InReady=0 expected 1 for input %0d", i);
        InValid = 0;
        return;
      end
      @(posedge Clock); #1;
      if (i == start_at) begin Start = 1; BlockLen = 3; end
      if (i == drop_at) Start = 0;
      if (i == stall_at) stall = 5;
    end
    InValid = 0;
  endtask

  task automatic run_block(input int k, input bit gaps, input bit push, input int start_at,
                           input int drop_at, input int stall_at);
    wait_idle();
    clear_log();
    if (push) model_block(k);
    Start = 1; BlockLen = KW'(k);
    @(posedge Clock); #1;
    if (start_at < 0) Start = 0;
    feed(k, start_at, drop_at, stall_at, gaps);
    Start = 0;
    wait_drain();
  endtask

  task automatic check_k4_pattern(input string tag);
    logic [31:0] s, p, t;
    int d;
    pack_log(s, p, t, d);
    check({tag, "_sys"}, s, E_SYS);
    check({tag, "_par"}, p, E_PAR);
    check({tag, "_tail"}, t, E_TAIL);
    check({tag, "_done_idx"}, d, 32'(3 + NT));
  endtask

  initial begin
    logic [31:0] s, p, t;
    int d, k;
    pair_t e;
    Reset = 1; Start = 0; InValid = 0; InBit = 0; BlockLen = '0; OutReady = 0;
    repeat (3) @(posedge Clock);
    #1;
    check("reset_state", {25'd0, OutValid, OutSys, OutPar, OutTail, InReady, Busy, Done}, 32'd0);
    Reset = 0;
    chk_en = 1;

    // K=4, 1000: pin the model against hand-derived values, then the DUT against the same.
    rdy_pct = 100;
    in_bits[0] = 1; in_bits[1] = 0; in_bits[2] = 0; in_bits[3] = 0;
    model_block(4);
    s = 0; p = 0; t = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      s = (s << 1) | 32'(e.sys); p = (p << 1) | 32'(e.par); t = (t << 1) | 32'(e.tail);
    end
    check("model_sys", s, E_SYS);
    check("model_par", p, E_PAR);
    check("model_tail", t, E_TAIL);
    run_block(4, 0, 0, -1, -1, -1);
    check_k4_pattern("k4");

    // K=8 all zero.
    rdy_pct = 60;
    for (int i = 0; i < 8; i++) in_bits[i] = 0;
    run_block(8, 1, 1, -1, -1, -1);
    pack_log(s, p, t, d);
    check("zero_sys_par", s | p, 32'd0);
    check("zero_count", log_sys.size(), 32'(8 + NT));
    check("zero_done_idx", d, 32'(7 + NT));

    // Output stall mid-block.
    rdy_pct = 100;
    for (int i = 0; i < 10; i++) in_bits[i] = 1'($urandom_range(1));
    run_block(10, 0, 1, -1, -1, 3);
    check("stall_count", log_sys.size(), 32'(10 + NT));

    // Reset after 2 of 6 inputs.
    wait_idle();
    clear_log();
    for (int i = 0; i < 6; i++) in_bits[i] = 1'($urandom_range(1));
    model_block(6);
    Start = 1; BlockLen = 6;
    @(posedge Clock); #1;
    Start = 0;
    feed(2, -1, -1, -1, 0);
    chk_en = 0;
    Reset = 1;
    @(posedge Clock); #1;
    check("midreset_outs", {25'd0, OutValid, OutSys, OutPar, OutTail, InReady, Busy, Done}, 32'd0);
    Reset = 0;
    exp_q.delete();
    chk_en = 1;
    in_bits[0] = 1; in_bits[1] = 0; in_bits[2] = 0; in_bits[3] = 0;
    run_block(4, 0, 1, -1, -1, -1);
    check_k4_pattern("post_reset");

    // Start with BlockLen=0 is ignored.
    wait_idle();
    Start = 1; BlockLen = 0;
    @(posedge Clock); #1;
    Start = 0;
    check("len0_busy_a", {31'd0, Busy}, 32'd0);
    @(posedge Clock); #1;
    check("len0_busy_b", {31'd0, Busy}, 32'd0);

    // Start (BlockLen=3) pulsed during DATA of a K=5 block is ignored.
    rdy_pct = 80;
    for (int i = 0; i < 5; i++) in_bits[i] = 1'($urandom_range(1));
    run_block(5, 1, 1, 1, 2, -1);
    check("start_in_data_count", log_sys.size(), 32'(5 + NT));

    // Two back-to-back K=4 blocks with Start held.
    rdy_pct = 100;
    wait_idle();
    clear_log();
    for (int i = 0; i < 8; i++) in_bits[i] = (i % 4 == 2) ? 1'b0 : 1'b1;
    model_block(4);
    model_block(4);
    Start = 1; BlockLen = 4;
    @(posedge Clock); #1;
    feed(8, -1, 4, -1, 0);
    Start = 0;
    wait_drain();
    check("b2b_count", log_sys.size(), 32'(8 + 2 * NT));
    if (log_sys.size() == 8 + 2 * NT) begin
      check("b2b_first_a", {30'd0, log_sys[0], log_par[0]}, 32'b11);
      check("b2b_first_b", {30'd0, log_sys[4 + NT], log_par[4 + NT]}, 32'b11);
    end

    // Random blocks.
    for (int b = 0; b < 10; b++) begin
      k = $urandom_range(1, 20);
      rdy_pct = $urandom_range(30, 100);
      for (int i = 0; i < k; i++) in_bits[i] = 1'($urandom_range(1));
      run_block(k, 1, 1, -1, -1, -1);
      check("rand_count", log_sys.size(), 32'(k + NT));
    end

    repeat (3) @(posedge Clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rsc_encoder.md
RSC_ENCODER -- requirements
Module: rsc_encoder

Interface
REQ-001 SHALL have parameter KW, default 13, giving the width of the block-length port (K up to 2^KW-1).
REQ-002 SHALL have port Clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port Start, input, 1, a block-start request, sampled only in IDLE.
REQ-005 SHALL have port BlockLen, input, KW, the number of information bits K, latched when Start is accepted.
REQ-006 SHALL have port InBit, input, 1, the information bit u.
REQ-007 SHALL have port InValid, input, 1, meaning InBit is valid.
REQ-008 SHALL have port InReady, output, 1, meaning the encoder accepts InBit this cycle.
REQ-009 SHALL have port OutSys, output, 1, the systematic bit (information bit or tail bit).
REQ-010 SHALL have port OutPar, output, 1, the parity bit z.
REQ-011 SHALL have port OutTail, output, 1, meaning the current output pair is a termination pair.
REQ-012 SHALL have port OutValid, output, 1, meaning OutSys, OutPar and OutTail are valid.
REQ-013 SHALL have port OutReady, input, 1, meaning the downstream decoder front end accepts the output pair.
REQ-014 SHALL have port Busy, output, 1, high in any state other than IDLE.
REQ-015 SHALL have port Done, output, 1, a one-cycle pulse when the final output pair of a block transfers.

Function
REQ-016 SHALL implement the constituent code with feedback g0 = 1+D^2+D^3 and feedforward g1 = 1+D+D^3, using a 3-bit state (s1 newest, s3 oldest).
REQ-017 SHALL compute a = u^s2^s3 and z = a^s1^s3, then update the state to s1<=a, s2<=s1, s3<=s2.
REQ-018 SHALL use the FSM states IDLE, DATA and TAIL; the state SHALL clear to 000 when Start is accepted.
REQ-019 SHALL accept Start in IDLE only when BlockLen != 0, then go to DATA; Start with BlockLen == 0 SHALL be ignored.
REQ-020 SHALL raise InReady only in DATA and only when (!OutValid || OutReady).
REQ-021 SHALL transfer an input when InValid && InReady, transfer an output when OutValid && OutReady, and hold OutSys, OutPar and OutTail stable while OutValid && !OutReady.
REQ-022 SHALL register the output pair for an input transfer at cycle n so that OutValid=1 at cycle n+1, giving 1-cycle latency and full throughput under continuous handshakes.
REQ-023 SHALL count input transfers; the K-th transfer SHALL move the FSM to TAIL, or to IDLE when termination is compiled out.
REQ-024 SHALL, in TAIL, generate 3 tail pairs without input whenever (!OutValid || OutReady), using u = s2^s3 (so a = 0), OutSys = u, OutTail = 1; after the 3rd tail pair the state SHALL be 000 and the FSM SHALL return to IDLE.
REQ-025 SHALL pulse Done in the cycle the final pair transfers; a new Start SHALL be accepted once the FSM is in IDLE, while an OutValid pair still pending SHALL drain normally.
REQ-026 SHALL ignore InValid outside DATA and ignore Start outside IDLE.

Reset
REQ-027 SHALL, while Reset = 1 at a clock edge, set the FSM to IDLE, the state to 000, the counters to 0, and OutSys, OutPar, OutTail, OutValid, InReady, Busy and Done to 0.
REQ-028 SHALL, when Reset asserts mid-block, abandon the block with no Done pulse and drop any pending output pair.

Configuration
REQ-029 SHALL, with macro RSC_ENC_TERMINATION_EN defined, perform TAIL as specified, so each block emits K+3 pairs.
REQ-030 SHALL, with RSC_ENC_TERMINATION_EN undefined, remove the TAIL state and logic, emit exactly K pairs, hold OutTail at 0, and pulse Done on the K-th pair.

Verification
REQ-031 SHALL cover: K=4, input 1,0,0,0, OutReady=1 -> Sys 1,0,0,0 and Par 1,1,1,1; with termination, tail Sys 1,0,1, Par 1,1,1, OutTail=1, and Done on the 7th pair.
REQ-032 SHALL cover: K=8, all-zero input -> all OutSys/OutPar = 0, tail pairs 0/0, and state 000 at Done.
REQ-033 SHALL cover: OutReady low for 5 cycles mid-block -> InReady=0, outputs held stable, and no pair lost or duplicated.
REQ-034 SHALL cover: Reset pulsed after 2 of K=6 inputs -> all outputs 0 on the next cycle, no Done, and the next block encodes from state 000.
REQ-035 SHALL cover: Start with BlockLen=0 -> Busy stays 0, and Start during DATA is ignored.
REQ-036 SHALL cover: two back-to-back K=4 blocks with Start held -> the second block's first pair is identical to the first block's first pair.
